// File: rtl/rv32_dec_exe_core_pkg.sv
// Shared RV32I encodings and ALU operation set for the decode/execute slice.
package rv32_dec_exe_core_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_SLTU    = 3'b011;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [2:0] F3_SB   = 3'b000;
  localparam logic [2:0] F3_SH   = 3'b001;
  localparam logic [2:0] F3_SW   = 3'b010;
  localparam logic [2:0] F3_JALR = 3'b000;
  localparam logic [2:0] F3_ADDI = 3'b000;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [31:0] EBREAK_INST = 32'h00100073;

  typedef enum logic [3:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_SLL,
    ALU_SLT,
    ALU_SLTU,
    ALU_XOR,
    ALU_SRL,
    ALU_SRA,
    ALU_OR,
    ALU_AND,
    ALU_PASSB
  } alu_op_e;

endpackage

// File: rtl/rv32_dec_exe_core_regfile.sv
// 32-entry register file: two asynchronous read ports, one write port, x0 hardwired to zero.
module rv32_regfile
  import rv32_dec_exe_core_pkg::*;
#(
  parameter int DATA_LEN = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [4:0]          raddr1_i,
  input  logic [4:0]          raddr2_i,
  output logic [DATA_LEN-1:0] rdata1_o,
  output logic [DATA_LEN-1:0] rdata2_o,
  input  logic                we_i,
  input  logic [4:0]          waddr_i,
  input  logic [DATA_LEN-1:0] wdata_i
);

  logic [DATA_LEN-1:0] regs_q [32];

  // Synchronous clear has priority; writes to x0 are dropped.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) begin
        regs_q[i] <= {DATA_LEN{1'b0}};
      end
    end else if (we_i && (waddr_i != 5'd0)) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata1_o = (raddr1_i == 5'd0) ? {DATA_LEN{1'b0}} : regs_q[raddr1_i];
  assign rdata2_o = (raddr2_i == 5'd0) ? {DATA_LEN{1'b0}} : regs_q[raddr2_i];

endmodule

// File: rtl/rv32_dec_exe_core.sv
// Single-cycle RV32I decode/execute slice: decodes inst_i, reads the register file,
// and produces ALU writeback, branch/jump redirect and store request combinationally.
module rv32_dec_exe_core
  import rv32_dec_exe_core_pkg::*;
#(
  parameter int DATA_LEN = 32,
  parameter int ADDR_LEN = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [31:0]         inst_i,
  input  logic [ADDR_LEN-1:0] pc_i,
  output logic                branch_taken_o,
  output logic [ADDR_LEN-1:0] branch_target_o,
  output logic                jmp_flag_o,
  output logic [ADDR_LEN-1:0] jmp_target_o,
  output logic                mem_wen_o,
  output logic [ADDR_LEN-1:0] mem_addr_o,
  output logic [DATA_LEN-1:0] mem_wdata_o,
  output logic [3:0]          mem_wmask_o,
  output logic                rd_wen_o,
  output logic [4:0]          rd_addr_o,
  output logic [DATA_LEN-1:0] rd_wdata_o,
  output logic                invalid_o,
  output logic                ebreak_o
);

  localparam logic [DATA_LEN-1:0] INST_BYTES = {{(DATA_LEN-3){1'b0}}, 3'd4};
  localparam logic [ADDR_LEN-1:0] JALR_MASK  = {{(ADDR_LEN-1){1'b1}}, 1'b0};

  logic [6:0] opcode_s, funct7_s;
  logic [2:0] funct3_s;
  logic [4:0] rs1_addr_s, rs2_addr_s;
  logic [DATA_LEN-1:0] rs1_s, rs2_s;
  logic [DATA_LEN-1:0] imm_i_s, imm_s_s, imm_b_s, imm_u_s, imm_j_s;
  logic [DATA_LEN-1:0] alu_a_s, alu_b_s, alu_y_s;
  alu_op_e alu_op_s;
  logic valid_s, rd_wen_s, mem_wen_s, is_branch_s, is_jal_s, is_jalr_s, br_cond_s;
  logic [3:0] wmask_s;

  assign opcode_s   = inst_i[6:0];
  assign funct3_s   = inst_i[14:12];
  assign funct7_s   = inst_i[31:25];
  assign rs1_addr_s = inst_i[19:15];
  assign rs2_addr_s = inst_i[24:20];

  assign imm_i_s = {{(DATA_LEN-12){inst_i[31]}}, inst_i[31:20]};
  assign imm_s_s = {{(DATA_LEN-12){inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
  assign imm_b_s = {{(DATA_LEN-12){inst_i[31]}}, inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
  assign imm_u_s = {inst_i[31:12], {(DATA_LEN-20){1'b0}}};
  assign imm_j_s = {{(DATA_LEN-20){inst_i[31]}}, inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};

  rv32_regfile #(.DATA_LEN(DATA_LEN)) u_regfile (
    .clk      (clk),
    .rst      (rst),
    .raddr1_i (rs1_addr_s),
    .raddr2_i (rs2_addr_s),
    .rdata1_o (rs1_s),
    .rdata2_o (rs2_s),
    .we_i     (rd_wen_o),
    .waddr_i  (inst_i[11:7]),
    .wdata_i  (rd_wdata_o)
  );

  // Decode: classify the instruction and steer ALU operands; enables are gated by valid_s below.
  always_comb begin
    valid_s     = 1'b0;
    rd_wen_s    = 1'b0;
    mem_wen_s   = 1'b0;
    is_branch_s = 1'b0;
    is_jal_s    = 1'b0;
    is_jalr_s   = 1'b0;
    wmask_s     = 4'b0000;
    alu_op_s    = ALU_ADD;
    alu_a_s     = rs1_s;
    alu_b_s     = rs2_s;
    case (opcode_s)
      OPC_LUI: begin
        valid_s  = 1'b1;
        rd_wen_s = 1'b1;
        alu_op_s = ALU_PASSB;
        alu_b_s  = imm_u_s;
      end
      OPC_AUIPC: begin
        valid_s  = 1'b1;
        rd_wen_s = 1'b1;
        alu_a_s  = pc_i;
        alu_b_s  = imm_u_s;
      end
      OPC_JAL: begin
        valid_s  = 1'b1;
        rd_wen_s = 1'b1;
        is_jal_s = 1'b1;
        alu_a_s  = pc_i;
        alu_b_s  = INST_BYTES;
      end
      OPC_JALR: begin
        if (funct3_s == F3_JALR) begin
          valid_s   = 1'b1;
          rd_wen_s  = 1'b1;
          is_jalr_s = 1'b1;
          alu_a_s   = pc_i;
          alu_b_s   = INST_BYTES;
        end else begin
          valid_s = 1'b0;
        end
      end
      OPC_BRANCH: begin
        is_branch_s = 1'b1;
        case (funct3_s)
          F3_BEQ, F3_BNE, F3_BLT, F3_BGE, F3_BLTU, F3_BGEU: valid_s = 1'b1;
          default: valid_s = 1'b0;
        endcase
      end
      OPC_STORE: begin
        mem_wen_s = 1'b1;
        case (funct3_s)
          F3_SB: begin valid_s = 1'b1; wmask_s = 4'b0001; end
          F3_SH: begin valid_s = 1'b1; wmask_s = 4'b0011; end
          F3_SW: begin valid_s = 1'b1; wmask_s = 4'b1111; end
          default: valid_s = 1'b0;
        endcase
      end
      OPC_OP_IMM: begin
        rd_wen_s = 1'b1;
        alu_b_s  = imm_i_s;
        if (funct3_s == F3_ADDI) begin
          valid_s = 1'b1;
        end else begin
          valid_s = 1'b0;
        end
      end
      OPC_OP: begin
        rd_wen_s = 1'b1;
        if (funct7_s == F7_BASE) begin
          valid_s = 1'b1;
          case (funct3_s)
            F3_ADD_SUB: alu_op_s = ALU_ADD;
            F3_SLL:     alu_op_s = ALU_SLL;
            F3_SLT:     alu_op_s = ALU_SLT;
            F3_SLTU:    alu_op_s = ALU_SLTU;
            F3_XOR:     alu_op_s = ALU_XOR;
            F3_SRL_SRA: alu_op_s = ALU_SRL;
            F3_OR:      alu_op_s = ALU_OR;
            F3_AND:     alu_op_s = ALU_AND;
            default:    alu_op_s = ALU_ADD;
          endcase
        end else if (funct7_s == F7_ALT) begin
          case (funct3_s)
            F3_ADD_SUB: begin valid_s = 1'b1; alu_op_s = ALU_SUB; end
            F3_SRL_SRA: begin valid_s = 1'b1; alu_op_s = ALU_SRA; end
            default:    valid_s = 1'b0;
          endcase
        end else begin
          valid_s = 1'b0;
        end
      end
      OPC_SYSTEM: begin
        if (inst_i == EBREAK_INST) begin
          valid_s = 1'b1;
        end else begin
          valid_s = 1'b0;
        end
      end
      default: valid_s = 1'b0;
    endcase
  end

  // ALU shared by all writeback producers.
  always_comb begin
    alu_y_s = {DATA_LEN{1'b0}};
    case (alu_op_s)
      ALU_ADD:   alu_y_s = alu_a_s + alu_b_s;
      ALU_SUB:   alu_y_s = alu_a_s - alu_b_s;
      ALU_SLL:   alu_y_s = alu_a_s << alu_b_s[4:0];
      ALU_SLT:   alu_y_s = {{(DATA_LEN-1){1'b0}}, ($signed(alu_a_s) < $signed(alu_b_s))};
      ALU_SLTU:  alu_y_s = {{(DATA_LEN-1){1'b0}}, (alu_a_s < alu_b_s)};
      ALU_XOR:   alu_y_s = alu_a_s ^ alu_b_s;
      ALU_SRL:   alu_y_s = alu_a_s >> alu_b_s[4:0];
      ALU_SRA:   alu_y_s = $unsigned($signed(alu_a_s) >>> alu_b_s[4:0]);
      ALU_OR:    alu_y_s = alu_a_s | alu_b_s;
      ALU_AND:   alu_y_s = alu_a_s & alu_b_s;
      ALU_PASSB: alu_y_s = alu_b_s;
      default:   alu_y_s = {DATA_LEN{1'b0}};
    endcase
  end

  // Branch condition from funct3; only consumed when the opcode is BRANCH.
  always_comb begin
    br_cond_s = 1'b0;
    case (funct3_s)
      F3_BEQ:  br_cond_s = (rs1_s == rs2_s);
      F3_BNE:  br_cond_s = (rs1_s != rs2_s);
      F3_BLT:  br_cond_s = ($signed(rs1_s) < $signed(rs2_s));
      F3_BGE:  br_cond_s = ($signed(rs1_s) >= $signed(rs2_s));
      F3_BLTU: br_cond_s = (rs1_s < rs2_s);
      F3_BGEU: br_cond_s = (rs1_s >= rs2_s);
      default: br_cond_s = 1'b0;
    endcase
  end

  assign branch_taken_o  = valid_s & is_branch_s & br_cond_s;
  assign branch_target_o = pc_i + imm_b_s;
  assign jmp_flag_o      = valid_s & (is_jal_s | is_jalr_s);
  assign jmp_target_o    = is_jalr_s ? ((rs1_s + imm_i_s) & JALR_MASK) : (pc_i + imm_j_s);
  assign mem_wen_o       = valid_s & mem_wen_s;
  assign mem_addr_o      = rs1_s + imm_s_s;
  assign mem_wdata_o     = rs2_s;
  assign mem_wmask_o     = valid_s ? wmask_s : 4'b0000;
  assign rd_wen_o        = valid_s & rd_wen_s;
  assign rd_addr_o       = inst_i[11:7];
  assign rd_wdata_o      = alu_y_s;
  assign invalid_o       = ~valid_s;
  assign ebreak_o        = (inst_i == EBREAK_INST);

endmodule

// File: tb/tb_rv32_dec_exe_core.sv
// Directed bench for rv32_dec_exe_core: hand-computed expectations, register contents
// observed through the store data path (sw xN,0(x0) exposes xN on mem_wdata_o).
module tb_rv32_dec_exe_core;

  logic        clk;
  logic        rst;
  logic [31:0] inst_i;
  logic [31:0] pc_i;
  logic        branch_taken_o;
  logic [31:0] branch_target_o;
  logic        jmp_flag_o;
  logic [31:0] jmp_target_o;
  logic        mem_wen_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [3:0]  mem_wmask_o;
  logic        rd_wen_o;
  logic [4:0]  rd_addr_o;
  logic [31:0] rd_wdata_o;
  logic        invalid_o;
  logic        ebreak_o;

  int n_total = 0;
  int n_pass  = 0;

  rv32_dec_exe_core dut (
    .clk             (clk),
    .rst             (rst),
    .inst_i          (inst_i),
    .pc_i            (pc_i),
    .branch_taken_o  (branch_taken_o),
    .branch_target_o (branch_target_o),
    .jmp_flag_o      (jmp_flag_o),
    .jmp_target_o    (jmp_target_o),
    .mem_wen_o       (mem_wen_o),
    .mem_addr_o      (mem_addr_o),
    .mem_wdata_o     (mem_wdata_o),
    .mem_wmask_o     (mem_wmask_o),
    .rd_wen_o        (rd_wen_o),
    .rd_addr_o       (rd_addr_o),
    .rd_wdata_o      (rd_wdata_o),
    .invalid_o       (invalid_o),
    .ebreak_o        (ebreak_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
  endfunction

  function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Present an instruction half a cycle before the writing edge and let it settle.
  task automatic issue(input logic [31:0] inst, input logic [31:0] pc);
    @(negedge clk);
    inst_i = inst;
    pc_i   = pc;
    #1;
  endtask

  task automatic read_reg(input logic [4:0] r, input logic [31:0] exp, input string tag);
    issue(enc_s(12'd0, r, 5'd0, 3'b010), 32'h0);
    check(tag, mem_wdata_o, exp);
  endtask

  initial begin
    rst    = 1'b0;
    inst_i = 32'h00000013;
    pc_i   = 32'h0;
    repeat (2) @(posedge clk);

    // Reset: outputs follow inst_i, writes suppressed, registers cleared.
    issue(enc_i(12'd7, 5'd0, 3'b000, 5'd1, 7'b0010011), 32'h0);
    check("rst_comb_wen", {31'd0, rd_wen_o}, 32'd1);
    check("rst_comb_wdata", rd_wdata_o, 32'd7);
    read_reg(5'd1, 32'd0, "rst_x1_cleared");
    rst = 1'b1;
    read_reg(5'd1, 32'd0, "rst_x1_no_write");
    read_reg(5'd5, 32'd0, "rst_x5");

    // x0 stays zero.
    issue(32'h00500013, 32'h0);
    check("x0_wen", {31'd0, rd_wen_o}, 32'd1);
    check("x0_rd_addr", {27'd0, rd_addr_o}, 32'd0);
    read_reg(5'd0, 32'd0, "x0_read");

    // ADDI then R-type.
    issue(32'hFFD00093, 32'h0);
    check("addi_wdata", rd_wdata_o, 32'hFFFFFFFD);
    read_reg(5'd1, 32'hFFFFFFFD, "x1_after_addi");
    issue(enc_r(7'h00, 5'd1, 5'd0, 3'b011, 5'd2), 32'h0);
    check("sltu", rd_wdata_o, 32'd1);
    issue(enc_r(7'h00, 5'd0, 5'd1, 3'b010, 5'd3), 32'h0);
    check("slt", rd_wdata_o, 32'd1);
    read_reg(5'd2, 32'd1, "x2_after_sltu");
    issue(enc_r(7'h20, 5'd2, 5'd1, 3'b101, 5'd4), 32'h0);
    check("sra", rd_wdata_o, 32'hFFFFFFFE);
    issue(enc_r(7'h00, 5'd2, 5'd1, 3'b101, 5'd7), 32'h0);
    check("srl", rd_wdata_o, 32'h7FFFFFFE);
    issue(enc_r(7'h20, 5'd1, 5'd0, 3'b000, 5'd8), 32'h0);
    check("sub", rd_wdata_o, 32'd3);
    issue(enc_r(7'h00, 5'd2, 5'd1, 3'b001, 5'd10), 32'h0);
    check("sll", rd_wdata_o, 32'hFFFFFFFA);
    read_reg(5'd4, 32'hFFFFFFFE, "x4_after_sra");

    // LUI / AUIPC.
    issue({20'h12345, 5'd5, 7'b0110111}, 32'h0);
    check("lui", rd_wdata_o, 32'h12345000);
    issue({20'h00001, 5'd6, 7'b0010111}, 32'h80000010);
    check("auipc", rd_wdata_o, 32'h80001010);
    read_reg(5'd5, 32'h12345000, "x5_after_lui");

    // JAL / JALR.
    issue(enc_j(21'd8, 5'd1), 32'h80000000);
    check("jal_flag", {31'd0, jmp_flag_o}, 32'd1);
    check("jal_target", jmp_target_o, 32'h80000008);
    check("jal_wdata", rd_wdata_o, 32'h80000004);
    check("jal_no_branch", {31'd0, branch_taken_o}, 32'd0);
    read_reg(5'd1, 32'h80000004, "x1_after_jal");
    issue({20'h80000, 5'd9, 7'b0110111}, 32'h0);
    issue(enc_i(12'h101, 5'd9, 3'b000, 5'd9, 7'b0010011), 32'h0);
    issue(enc_i(12'h000, 5'd9, 3'b000, 5'd0, 7'b1100111), 32'h80000200);
    check("jalr_flag", {31'd0, jmp_flag_o}, 32'd1);
    check("jalr_target", jmp_target_o, 32'h80000100);
    check("jalr_wdata", rd_wdata_o, 32'h80000204);

    // Branches: x1 = -1, x2 = 1.
    issue(enc_i(12'hFFF, 5'd0, 3'b000, 5'd1, 7'b0010011), 32'h0);
    issue(enc_b(13'd8, 5'd2, 5'd1, 3'b100), 32'h0);
    check("blt_taken", {31'd0, branch_taken_o}, 32'd1);
    check("blt_wen", {31'd0, rd_wen_o}, 32'd0);
    check("blt_no_jmp", {31'd0, jmp_flag_o}, 32'd0);
    issue(enc_b(13'd8, 5'd2, 5'd1, 3'b110), 32'h0);
    check("bltu_taken", {31'd0, branch_taken_o}, 32'd0);
    issue(enc_b(13'd8, 5'd2, 5'd1, 3'b111), 32'h0);
    check("bgeu_taken", {31'd0, branch_taken_o}, 32'd1);
    issue(enc_b(13'h1FFC, 5'd0, 5'd0, 3'b000), 32'h00000100);
    check("beq_taken", {31'd0, branch_taken_o}, 32'd1);
    check("beq_target", branch_target_o, 32'h000000FC);
    issue(enc_b(13'd8, 5'd0, 5'd0, 3'b001), 32'h0);
    check("bne_not_taken", {31'd0, branch_taken_o}, 32'd0);

    // Store.
    issue(enc_i(12'h100, 5'd0, 3'b000, 5'd1, 7'b0010011), 32'h0);
    issue(enc_s(12'd6, 5'd2, 5'd1, 3'b001), 32'h0);
    check("sh_wen", {31'd0, mem_wen_o}, 32'd1);
    check("sh_addr", mem_addr_o, 32'h00000106);
    check("sh_mask", {28'd0, mem_wmask_o}, 32'h3);
    check("sh_wdata", mem_wdata_o, 32'd1);
    check("sh_rd_wen", {31'd0, rd_wen_o}, 32'd0);
    issue(enc_s(12'd0, 5'd2, 5'd1, 3'b000), 32'h0);
    check("sb_mask", {28'd0, mem_wmask_o}, 32'h1);

    // Invalid / EBREAK.
    issue(32'h00000003, 32'h0);
    check("lb_invalid", {31'd0, invalid_o}, 32'd1);
    check("lb_wen", {31'd0, rd_wen_o}, 32'd0);
    check("lb_mem_wen", {31'd0, mem_wen_o}, 32'd0);
    issue(enc_r(7'h20, 5'd0, 5'd0, 3'b001, 5'd2), 32'h0);
    check("badr_invalid", {31'd0, invalid_o}, 32'd1);
    check("badr_wen", {31'd0, rd_wen_o}, 32'd0);
    read_reg(5'd2, 32'd1, "x2_after_invalid");
    issue(enc_s(12'd0, 5'd2, 5'd1, 3'b011), 32'h0);
    check("sd_invalid", {31'd0, invalid_o}, 32'd1);
    check("sd_mem_wen", {31'd0, mem_wen_o}, 32'd0);
    issue(32'h00100073, 32'h0);
    check("ebreak", {31'd0, ebreak_o}, 32'd1);
    check("ebreak_valid", {31'd0, invalid_o}, 32'd0);
    check("ebreak_wen", {31'd0, rd_wen_o}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
